skintone_stream_ctrl: RTL and testbench

//  Frame sequencer and flow controller for skintone_datapath, which is a fixed-latency, non-stallable pipeline.
//  - Accepts YCbCr pixels on a valid/ready input stream and issues them to the datapath.
//  - Collects the 8-bit scores in an output FIFO, so downstream backpressure never drops a result.
//  - Frames one run of frame_len pixels with start, done and last framing.

---
 rtl/skintone_stream_ctrl.sv | 150 +++++++++++++++
 tb/tb_skintone_stream_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/skintone_stream_ctrl.sv
// Frame sequencer and credit-based flow controller for the fixed-latency skintone datapath.
// Results are parked in a first-word-fall-through FIFO whose slots are reserved at accept time.
module skintone_stream_ctrl #(
    parameter int LAT    = 16,
    parameter int DEPTH  = 32,
    parameter int FLEN_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FLEN_W-1:0] frame_len,
    output logic              busy,
    output logic              done,
    input  logic [23:0]       s_pixel,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [23:0]       dp_pixel,
    output logic              dp_valid,
    input  logic [7:0]        dp_result,
    input  logic              dp_result_valid,
    output logic [7:0]        m_score,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              err_overflow
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = $clog2(LAT + 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [FW-1:0]     r_flush;
    logic [FLEN_W-1:0] r_len;
    logic [FLEN_W-1:0] r_issued;
    logic [FLEN_W-1:0] r_retired;
    logic [CW-1:0]     r_inflight;
    logic [CW-1:0]     r_count;
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [8:0]        r_mem [DEPTH];
    logic [23:0]       r_dp_pixel;
    logic              r_dp_valid;
    logic              r_err;

    logic              w_hs;
    logic              w_cap;
    logic              w_rd;
    logic              w_wr;
    logic              w_full;
    logic              w_last;
    logic [CW:0]       w_occ;
    logic [8:0]        w_head;

    // Inflight credits plus stored results bound the FIFO occupancy.
    assign w_occ   = {1'b0, r_inflight} + {1'b0, r_count};
    assign s_ready = (r_state == S_RUN) && (w_occ < (CW+1)'(DEPTH));
    assign w_hs    = s_valid && s_ready;
    assign w_cap   = dp_result_valid && (r_inflight != '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_rd    = m_valid && m_ready;
    assign w_wr    = w_cap && (!w_full || w_rd);
    assign w_last  = ((r_retired + FLEN_W'(1)) == r_len);
    assign w_head  = r_mem[r_rptr];

    assign busy         = rst && (r_state != S_IDLE);
    assign done         = (r_state == S_DONE);
    assign dp_pixel     = r_dp_pixel;
    assign dp_valid     = r_dp_valid;
    assign m_valid      = (r_count != '0);
    assign m_score      = m_valid ? w_head[7:0] : '0;
    assign m_last       = m_valid && w_head[8];
    assign err_overflow = r_err;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_FLUSH: if (r_flush == FW'(LAT)) w_next = S_IDLE;
            S_IDLE:  if (start) w_next = (frame_len == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_hs && ((r_issued + FLEN_W'(1)) == r_len)) w_next = S_DRAIN;
            S_DRAIN: if ((r_inflight == '0) && (r_count == '0)) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_FLUSH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FLUSH;
            r_flush    <= '0;
            r_len      <= '0;
            r_issued   <= '0;
            r_retired  <= '0;
            r_inflight <= '0;
            r_dp_pixel <= '0;
            r_dp_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_flush    <= (r_state == S_FLUSH) ? r_flush + FW'(1) : '0;
            r_dp_valid <= w_hs;
            if (w_hs) r_dp_pixel <= s_pixel;
            if (r_state == S_IDLE && start) begin
                r_len     <= frame_len;
                r_issued  <= '0;
                r_retired <= '0;
            end else begin
                if (w_hs)  r_issued  <= r_issued + FLEN_W'(1);
                if (w_cap) r_retired <= r_retired + FLEN_W'(1);
            end
            unique case ({w_hs, w_cap})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
            if (w_cap && w_full && !w_rd) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) r_wptr <= (r_wptr == AW'(DEPTH - 1)) ? '0 : r_wptr + AW'(1);
            if (w_rd) r_rptr <= (r_rptr == AW'(DEPTH - 1)) ? '0 : r_rptr + AW'(1);
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: m_valid qualifies every read.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= {w_last, dp_result};
    end

endmodule

// File: tb/tb_skintone_stream_ctrl.sv
// Directed + randomized bench for skintone_stream_ctrl with a LAT-deep datapath stub
// and a queue-based reference of expected scores.
module tb_skintone_stream_ctrl;

    localparam int LAT    = 16;
    localparam int DEPTH  = 32;
    localparam int FLEN_W = 20;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [FLEN_W-1:0] frame_len = '0;
    logic              busy;
    logic              done;
    logic [23:0]       s_pixel = '0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic [23:0]       dp_pixel;
    logic              dp_valid;
    logic [7:0]        dp_result;
    logic              dp_result_valid;
    logic [7:0]        m_score;
    logic              m_valid;
    logic              m_ready = 1'b0;
    logic              m_last;
    logic              err_overflow;

    always #5 clk = ~clk;

    skintone_stream_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .FLEN_W(FLEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .busy(busy), .done(done),
        .s_pixel(s_pixel), .s_valid(s_valid), .s_ready(s_ready),
        .dp_pixel(dp_pixel), .dp_valid(dp_valid),
        .dp_result(dp_result), .dp_result_valid(dp_result_valid),
        .m_score(m_score), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .err_overflow(err_overflow)
    );

    // datapath stub: score = Cr, LAT cycles after dp_valid, never reset
    logic [LAT-1:0] stub_v = '0;
    logic [7:0]     stub_d [LAT];
    always @(posedge clk) begin
        stub_v    <= {stub_v[LAT-2:0], dp_valid};
        stub_d[0] <= dp_pixel[7:0];
        for (int i = 1; i < LAT; i++) stub_d[i] <= stub_d[i-1];
    end
    assign dp_result_valid = stub_v[LAT-1];
    assign dp_result       = stub_d[LAT-1];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference model state
    logic [8:0] exp_q[$];
    int   acc_idx, pop_idx, cur_len, done_cnt;
    int   first_acc, last_acc, first_m, done_cyc, cyc, stray;
    bit   sb_on = 1'b0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [7:0] ps = '0;
    logic [7:0] next_cr;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sb_on && rst) begin
            if (s_valid && s_ready) begin
                if (acc_idx == 0) first_acc = cyc;
                last_acc = cyc;
                exp_q.push_back({acc_idx == cur_len - 1, s_pixel[7:0]});
                acc_idx++;
            end
            if (m_valid && first_m < 0) first_m = cyc;
            if (pv && !pr) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_score", m_score, ps);
                chk("hold_last", m_last, pl);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_score", 1, 0);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("score", m_score, e[7:0]);
                    chk("last", m_last, e[8]);
                end
                pop_idx++;
            end
            chk("occupancy_ok", (acc_idx - pop_idx >= 0) && (acc_idx - pop_idx <= DEPTH), 1);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        if (!sb_on && dp_result_valid) stray++;
        pv = m_valid; pr = m_ready; ps = m_score; pl = m_last;
    end

    task automatic drive(input int vpct, input int rpct, input bit poke);
        s_pixel = {8'($urandom), 8'($urandom), next_cr};
        s_valid = ($urandom_range(99) < vpct);
        m_ready = ($urandom_range(99) < rpct);
        start   = poke && (pop_idx < cur_len) && ($urandom_range(9) == 0);
        if (start) frame_len = 7;
    endtask

    task automatic step(input int vpct, input int rpct, input bit poke);
        bit hs;
        @(negedge clk);
        hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (hs) next_cr++;
        drive(vpct, rpct, poke);
    endtask

    task automatic begin_frame(input int len);
        exp_q.delete();
        acc_idx = 0; pop_idx = 0; cur_len = len; done_cnt = 0;
        first_acc = -1; first_m = -1; last_acc = -1; done_cyc = -1;
        next_cr = 8'd1;
        s_valid = 1'b0;
        frame_len = FLEN_W'(len);
        start = 1'b1;
        sb_on = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input int len);
        start = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (3) step(0, 100, 0);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_pops"}, pop_idx, len);
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_no_overflow"}, err_overflow, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        // 1: reset, then FLUSH with start held high
        start = 1'b1;
        frame_len = 5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mvalid", m_valid, 0);
        chk("rst_dpvalid", dp_valid, 0);
        chk("rst_err", err_overflow, 0);
        rst = 1'b1;
        for (int i = 0; i < LAT + 1; i++) begin
            @(negedge clk);
            chk("flush_busy", busy, 1);
            chk("flush_sready", s_ready, 0);
        end
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_sready", s_ready, 0);
        start = 1'b0;
        @(negedge clk);
        chk("idle_stays", busy, 0);
        @(posedge clk);
        #1;

        // 2: len=4, full rate
        begin_frame(4);
        drive(100, 100, 0);
        for (int n = 0; n < 200 && done_cnt == 0; n++) step(100, 100, 0);
        chk("t2_accepts", acc_idx, 4);
        chk("t2_consecutive", last_acc - first_acc, 3);
        chk("t2_latency", first_m - first_acc, LAT + 2);
        chk("t2_done_after", done_cyc > last_acc, 1);
        finish_frame("t2", 4);

        // 4: zero-length frame
        sb_on = 1'b0;
        frame_len = '0;
        start = 1'b1;
        @(negedge clk);
        chk("t4_pre_done", done, 0);
        chk("t4_pre_sready", s_ready, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 1);
        chk("t4_sready", s_ready, 0);
        @(negedge clk);
        chk("t4_done_end", done, 0);
        chk("t4_idle", busy, 0);
        @(posedge clk);
        #1;

        // 3: len=100 with downstream stalled
        begin_frame(100);
        drive(100, 0, 0);
        for (int n = 0; n < 60; n++) step(100, 0, 0);
        chk("t3_accepts", acc_idx, DEPTH);
        chk("t3_sready", s_ready, 0);
        chk("t3_err", err_overflow, 0);
        for (int n = 0; n < 1000 && done_cnt == 0; n++) step(100, 100, 0);
        finish_frame("t3", 100);

        // 5: len=50, random valid/ready, stray starts in RUN/DRAIN
        begin_frame(50);
        drive(50, 50, 1);
        for (int n = 0; n < 3000 && done_cnt == 0; n++) step(50, 50, 1);
        finish_frame("t5", 50);

        // 6: reset mid-frame after 10 accepts
        begin_frame(20);
        drive(100, 0, 0);
        for (int n = 0; n < 100 && acc_idx < 10; n++) step(100, 0, 0);
        chk("t6_accepts", acc_idx, 10);
        s_valid = 1'b0;
        sb_on = 1'b0;
        stray = 0;
        rst = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_sready", s_ready, 0);
        chk("t6_dpvalid", dp_valid, 0);
        chk("t6_dppixel", dp_pixel, 0);
        chk("t6_mvalid", m_valid, 0);
        chk("t6_mscore", m_score, 0);
        chk("t6_mlast", m_last, 0);
        chk("t6_err", err_overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            chk("t6_stray_mvalid", m_valid, 0);
        end
        chk("t6_strays_seen", stray > 0, 1);
        chk("t6_stray_err", err_overflow, 0);
        for (int n = 0; n < 40 && busy; n++) @(negedge clk);
        chk("t6_back_idle", busy, 0);
        @(posedge clk);
        #1;
        begin_frame(3);
        drive(100, 100, 0);
        for (int n = 0; n < 200 && done_cnt == 0; n++) step(100, 100, 0);
        finish_frame("t6_recover", 3);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
